execute: RTL and testbench
==========================

# execute

Execute (EX) stage of the 16-bit RISC pipeline. It selects the second ALU operand from the register file or the sign-extended immediate and decodes the ALU operation from `inp_aluOp` and `inp_fucn`. It computes the 16-bit result and a zero flag, then registers both into the EX/MEM boundary. It sits between decode (operands, immediate, control) and the memory/branch logic (address, branch compare).

## Interface
Parameters:
- `WIDTH`, default 16, datapath width; all arithmetic is modulo 2^WIDTH.

Ports (module name `execute`):
- `inp_clk`  in  1  stage clock; all state updates on the rising edge.
- `inp_rst_n`  in  1  reset, asynchronous and active-low.
- `inp_aluSrc`  in  1  operand B select: 0 = `inp_data2`, 1 = `inp_immidate`.
- `inp_aluOp`  in  2  op class: 0 = R-type (use `inp_fucn`), 1 = ADD, 2 = SUB, 3 = OR.
- `inp_fucn`  in  4  R-type function code; ignored unless `inp_aluOp` = 0.
- `inp_data1`  in  16  operand A (rs).
- `inp_data2`  in  16  register operand B (rt).
- `inp_immidate`  in  16  immediate, already sign-extended by decode; used unmodified.
- `out_zero`  out  1  registered, 1 when the registered result equals 0.
- `out_aluResult`  out  16  registered ALU result.

## Operation
- Operand selection: B = `inp_aluSrc` ? `inp_immidate` : `inp_data2`; A = `inp_data1`.
- Op-class decode:
  - `inp_aluOp` 1: A+B.
  - `inp_aluOp` 2: A−B.
  - `inp_aluOp` 3: A|B.
  - `inp_aluOp` 0: use the function-code decode below.
- Function codes (`inp_aluOp` = 0):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT: signed two's complement, result 16'h0001 if A<B, else 0.
  - 7 SLL: A << B[3:0].
  - 8 SRL: A >> B[3:0], logical.
  - 9 SRA: A >>> B[3:0], arithmetic.
  - 10–15: result 16'h0000.
- Arithmetic:
  - ADD/SUB wrap modulo 2^16.
  - No carry or overflow output; overflow is silently discarded.
  - Shift amounts use only B[3:0]; upper bits of B are ignored.
- Zero flag:
  - Computed combinationally from the next result (result == 16'h0000).
  - Registered in the same edge as the result, so `out_zero` always matches `out_aluResult`.
  - Codes 10–15 therefore yield `out_zero` = 1.

## Timing
- Latency: 1 cycle. Inputs sampled at rising edge N appear on the outputs after edge N and hold until edge N+1.
- No handshake and no stall; a new operation is accepted every cycle.
- Reset (`inp_rst_n` = 0), asynchronous and independent of the clock:
  - `out_aluResult` = 16'h0000 and `out_zero` = 0 immediately.
  - Both hold these values while reset is asserted.
- `out_zero` resets to 0 even though the reset result is 0; it is defined as 1 only after the first post-reset capture.
- Reset released mid-operation: the first rising edge with `inp_rst_n` = 1 captures the current inputs; no earlier operation is replayed.
- Input changes between edges have no effect on the outputs.

## Structure
- Shared package `execute_pkg`:
  - aluOp encodings: ALUOP_RTYPE = 0, ALUOP_ADD = 1, ALUOP_SUB = 2, ALUOP_OR = 3.
  - 4-bit function code constants FN_ADD … FN_SRA.
  - Decode, control and test bench all import these.
- One combinational sub-module `alu_core`:
  - Inputs: A, B, 4-bit internal op.
  - Outputs: result, zero.
- The top module contains:
  - the operand mux;
  - the aluOp/fucn to internal-op decode;
  - the output register with asynchronous active-low clear.

## Test plan
A = 4, B(reg) = 3, imm = 2; outputs checked one clock after each apply.
- Reset: assert `inp_rst_n` = 0 between edges -> outputs drop to 0000/0 at once with no clock edge; release, apply aluOp = 1, src = 0 -> 0007, zero 0 after next edge.
- Op classes with src = 0 / src = 1:
  - aluOp 1 -> 0007 / 0006.
  - aluOp 2 -> 0001 / 0002.
  - aluOp 3 -> 0007 / 0006.
- aluOp = 0, src = 0, fucn 0..7 -> 0007, 0001, 0000 (zero = 1), 0007, 0007, FFF8, 0000 (zero = 1), 0020.
- Signed and shift edges:
  - A = FFFF, B = 0001, SLT -> 0001.
  - A = 8000, B = 0004, SRA -> F800.
  - SRL with the same operands -> 0800.
  - fucn 12 -> 0000, zero = 1.
- Wrap: A = FFFF, B = 0001, ADD -> 0000, zero = 1.
- Wrap: A = 0000, B = 0001, SUB -> FFFF, zero = 0.

Source files
------------

// File: rtl/execute_pkg.sv
// Shared definitions for the execute stage: op-class encodings, R-type
// function codes, the internal ALU operation set and the decode helper
// that maps (aluOp, fucn) onto that internal operation.
package execute_pkg;

  localparam int ALUOP_W = 2;
  localparam int FN_W    = 4;

  // Op class supplied by the main decoder.
  typedef enum logic [ALUOP_W-1:0] {
    ALUOP_RTYPE = 2'd0,
    ALUOP_ADD   = 2'd1,
    ALUOP_SUB   = 2'd2,
    ALUOP_OR    = 2'd3
  } aluop_e;

  // R-type function codes, meaningful only when the op class is R-type.
  localparam logic [FN_W-1:0] FN_ADD = 4'd0;
  localparam logic [FN_W-1:0] FN_SUB = 4'd1;
  localparam logic [FN_W-1:0] FN_AND = 4'd2;
  localparam logic [FN_W-1:0] FN_OR  = 4'd3;
  localparam logic [FN_W-1:0] FN_XOR = 4'd4;
  localparam logic [FN_W-1:0] FN_NOR = 4'd5;
  localparam logic [FN_W-1:0] FN_SLT = 4'd6;
  localparam logic [FN_W-1:0] FN_SLL = 4'd7;
  localparam logic [FN_W-1:0] FN_SRL = 4'd8;
  localparam logic [FN_W-1:0] FN_SRA = 4'd9;

  // Internal operation handed to the ALU core. OP_ZERO covers the
  // unassigned function codes, which must produce an all-zero result.
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOR  = 4'd5,
    OP_SLT  = 4'd6,
    OP_SLL  = 4'd7,
    OP_SRL  = 4'd8,
    OP_SRA  = 4'd9,
    OP_ZERO = 4'd15
  } alu_op_e;

  // Map the op class and function code onto an internal ALU operation.
  // The function code is looked at only for the R-type class.
  function automatic alu_op_e decode_alu_op(input logic [ALUOP_W-1:0] alu_op,
                                             input logic [FN_W-1:0]    fucn);
    alu_op_e op;
    op = OP_ZERO;
    case (aluop_e'(alu_op))
      ALUOP_ADD: op = OP_ADD;
      ALUOP_SUB: op = OP_SUB;
      ALUOP_OR:  op = OP_OR;
      ALUOP_RTYPE: begin
        case (fucn)
          FN_ADD:  op = OP_ADD;
          FN_SUB:  op = OP_SUB;
          FN_AND:  op = OP_AND;
          FN_OR:   op = OP_OR;
          FN_XOR:  op = OP_XOR;
          FN_NOR:  op = OP_NOR;
          FN_SLT:  op = OP_SLT;
          FN_SLL:  op = OP_SLL;
          FN_SRL:  op = OP_SRL;
          FN_SRA:  op = OP_SRA;
          default: op = OP_ZERO;
        endcase
      end
      default: op = OP_ZERO;
    endcase
    return op;
  endfunction

endpackage : execute_pkg

// File: rtl/execute_if.sv
// Decode-to-execute bundle: operands, immediate and ALU control going in,
// registered result and zero flag coming back out toward memory/branch.
interface execute_if
  import execute_pkg::*;
#(
  parameter int WIDTH = 16
);

  logic               inp_aluSrc;
  logic [ALUOP_W-1:0] inp_aluOp;
  logic [FN_W-1:0]    inp_fucn;
  logic [WIDTH-1:0]   inp_data1;
  logic [WIDTH-1:0]   inp_data2;
  logic [WIDTH-1:0]   inp_immidate;
  logic               out_zero;
  logic [WIDTH-1:0]   out_aluResult;

  // Decode side: drives operands and control, observes the result.
  modport master (
    output inp_aluSrc, inp_aluOp, inp_fucn, inp_data1, inp_data2, inp_immidate,
    input  out_zero, out_aluResult
  );

  // Execute stage side.
  modport slave (
    input  inp_aluSrc, inp_aluOp, inp_fucn, inp_data1, inp_data2, inp_immidate,
    output out_zero, out_aluResult
  );

endinterface : execute_if

// File: rtl/execute_alu_core.sv
// Purely combinational ALU core: computes the result of one internal
// operation on A and B plus a flag that is set when the result is zero.
// Arithmetic wraps; shift amounts use only the low four bits of B.
module alu_core
  import execute_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  alu_op_e          op_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o
);

  logic [3:0]       shamt_s;
  logic [WIDTH-1:0] one_s;

  assign shamt_s = b_i[3:0];
  assign one_s   = {{(WIDTH-1){1'b0}}, 1'b1};

  // Result selection for every internal operation; unknown ops give zero.
  always_comb begin
    result_o = '0;
    case (op_i)
      OP_ADD:  result_o = a_i + b_i;
      OP_SUB:  result_o = a_i - b_i;
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_NOR:  result_o = ~(a_i | b_i);
      OP_SLT: begin
        if ($signed(a_i) < $signed(b_i)) begin
          result_o = one_s;
        end else begin
          result_o = '0;
        end
      end
      OP_SLL:  result_o = a_i << shamt_s;
      OP_SRL:  result_o = a_i >> shamt_s;
      OP_SRA:  result_o = $signed(a_i) >>> shamt_s;
      OP_ZERO: result_o = '0;
      default: result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule : alu_core

// File: rtl/execute.sv
// Execute stage of the 16-bit RISC pipeline. Selects operand B, decodes the
// ALU operation, evaluates it in alu_core and registers result and zero flag
// into the EX/MEM boundary. One-cycle latency, no stall, a new operation
// every cycle. The zero flag comes out of reset low and only becomes
// meaningful after the first capture.
module execute
  import execute_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic      inp_clk,
  input  logic      inp_rst_n,
  execute_if.slave  bus
);

  logic [WIDTH-1:0] op_b_s;
  alu_op_e          alu_op_s;
  logic [WIDTH-1:0] result_d;
  logic             zero_d;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;

  // Operand B: register operand or the already sign-extended immediate.
  always_comb begin
    op_b_s = bus.inp_data2;
    if (bus.inp_aluSrc) begin
      op_b_s = bus.inp_immidate;
    end else begin
      op_b_s = bus.inp_data2;
    end
  end

  // Translate op class and function code into the internal ALU op.
  always_comb begin
    alu_op_s = decode_alu_op(bus.inp_aluOp, bus.inp_fucn);
  end

  alu_core #(
    .WIDTH (WIDTH)
  ) u_alu_core (
    .a_i      (bus.inp_data1),
    .b_i      (op_b_s),
    .op_i     (alu_op_s),
    .result_o (result_d),
    .zero_o   (zero_d)
  );

  // EX/MEM register: result and zero flag captured on the same edge so
  // they always describe the same operation; cleared asynchronously.
  always_ff @(posedge inp_clk or negedge inp_rst_n) begin
    if (!inp_rst_n) begin
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.out_aluResult = result_q;
  assign bus.out_zero      = zero_q;

endmodule : execute

// File: tb/tb_execute.sv
// Scoreboard bench for the execute stage. Stimulus pushes hand-computed
// expectations into a queue when it drives an operation; an independent
// monitor pops and compares one clock later.
module tb_execute;
  import execute_pkg::*;

  typedef struct {
    logic [15:0] res;
    logic        zero;
    string       name;
  } exp_t;

  logic inp_clk;
  logic inp_rst_n;
  logic drive_valid;
  logic out_valid;
  int   checks;
  int   errors;
  exp_t sb_q[$];

  execute_if #(.WIDTH(16)) bus ();

  execute #(.WIDTH(16)) dut (
    .inp_clk   (inp_clk),
    .inp_rst_n (inp_rst_n),
    .bus       (bus.slave)
  );

  initial inp_clk = 1'b0;
  always #5 inp_clk = ~inp_clk;

  // Bench-side latency tracker: an op driven before an edge is visible after it.
  always @(posedge inp_clk) out_valid <= drive_valid;

  // Monitor: compare DUT output against the oldest pending expectation.
  always @(negedge inp_clk) begin
    if (out_valid === 1'b1) begin
      exp_t e;
      checks = checks + 1;
      if (sb_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_output: got %h/%b with no expectation pending",
                 bus.out_aluResult, bus.out_zero);
      end else begin
        e = sb_q.pop_front();
        if (bus.out_aluResult !== e.res || bus.out_zero !== e.zero) begin
          errors = errors + 1;
          $display("FAIL %s: got result=%h zero=%b, expected result=%h zero=%b",
                   e.name, bus.out_aluResult, bus.out_zero, e.res, e.zero);
        end
      end
    end
  end

  task automatic apply(input logic src, input logic [1:0] op, input logic [3:0] fn,
                       input logic [15:0] a, input logic [15:0] b, input logic [15:0] imm,
                       input logic [15:0] exp_res, input logic exp_zero, input string name);
    exp_t e;
    @(negedge inp_clk);
    bus.inp_aluSrc   = src;
    bus.inp_aluOp    = op;
    bus.inp_fucn     = fn;
    bus.inp_data1    = a;
    bus.inp_data2    = b;
    bus.inp_immidate = imm;
    drive_valid      = 1'b1;
    e.res  = exp_res;
    e.zero = exp_zero;
    e.name = name;
    sb_q.push_back(e);
  endtask

  // Stop issuing and wait (bounded) for every expectation to be consumed.
  task automatic drain();
    int n;
    @(negedge inp_clk);
    drive_valid = 1'b0;
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(negedge inp_clk);
      n = n + 1;
    end
    if (sb_q.size() != 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL drain_timeout: %0d expectations still pending, required 0", sb_q.size());
      sb_q.delete();
    end
    @(negedge inp_clk);
  endtask

  task automatic check_now(input logic [15:0] exp_res, input logic exp_zero, input string name);
    checks = checks + 1;
    if (bus.out_aluResult !== exp_res || bus.out_zero !== exp_zero) begin
      errors = errors + 1;
      $display("FAIL %s: got result=%h zero=%b, expected result=%h zero=%b",
               name, bus.out_aluResult, bus.out_zero, exp_res, exp_zero);
    end
  endtask

  // Global watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks           = 0;
    errors           = 0;
    drive_valid      = 1'b0;
    out_valid        = 1'b0;
    inp_rst_n        = 1'b0;
    bus.inp_aluSrc   = 1'b0;
    bus.inp_aluOp    = 2'd0;
    bus.inp_fucn     = 4'd0;
    bus.inp_data1    = 16'h0000;
    bus.inp_data2    = 16'h0000;
    bus.inp_immidate = 16'h0000;

    #3;
    check_now(16'h0000, 1'b0, "reset_initial");
    repeat (2) @(negedge inp_clk);
    inp_rst_n = 1'b1;

    // Op classes, register and immediate operand.
    apply(1'b0, ALUOP_ADD, 4'd0, 16'd4, 16'd3, 16'd2, 16'h0007, 1'b0, "add_reg");
    apply(1'b1, ALUOP_ADD, 4'd0, 16'd4, 16'd3, 16'd2, 16'h0006, 1'b0, "add_imm");
    apply(1'b0, ALUOP_SUB, 4'd0, 16'd4, 16'd3, 16'd2, 16'h0001, 1'b0, "sub_reg");
    apply(1'b1, ALUOP_SUB, 4'd0, 16'd4, 16'd3, 16'd2, 16'h0002, 1'b0, "sub_imm");
    apply(1'b0, ALUOP_OR,  4'd0, 16'd4, 16'd3, 16'd2, 16'h0007, 1'b0, "or_reg");
    apply(1'b1, ALUOP_OR,  4'd0, 16'd4, 16'd3, 16'd2, 16'h0006, 1'b0, "or_imm");

    // R-type function codes 0..7.
    apply(1'b0, ALUOP_RTYPE, FN_ADD, 16'd4, 16'd3, 16'd2, 16'h0007, 1'b0, "fn_add");
    apply(1'b0, ALUOP_RTYPE, FN_SUB, 16'd4, 16'd3, 16'd2, 16'h0001, 1'b0, "fn_sub");
    apply(1'b0, ALUOP_RTYPE, FN_AND, 16'd4, 16'd3, 16'd2, 16'h0000, 1'b1, "fn_and");
    apply(1'b0, ALUOP_RTYPE, FN_OR,  16'd4, 16'd3, 16'd2, 16'h0007, 1'b0, "fn_or");
    apply(1'b0, ALUOP_RTYPE, FN_XOR, 16'd4, 16'd3, 16'd2, 16'h0007, 1'b0, "fn_xor");
    apply(1'b0, ALUOP_RTYPE, FN_NOR, 16'd4, 16'd3, 16'd2, 16'hFFF8, 1'b0, "fn_nor");
    apply(1'b0, ALUOP_RTYPE, FN_SLT, 16'd4, 16'd3, 16'd2, 16'h0000, 1'b1, "fn_slt");
    apply(1'b0, ALUOP_RTYPE, FN_SLL, 16'd4, 16'd3, 16'd2, 16'h0020, 1'b0, "fn_sll");

    // Signed and shift edges.
    apply(1'b0, ALUOP_RTYPE, FN_SLT, 16'hFFFF, 16'h0001, 16'h0000, 16'h0001, 1'b0, "slt_signed");
    apply(1'b0, ALUOP_RTYPE, FN_SRA, 16'h8000, 16'h0004, 16'h0000, 16'hF800, 1'b0, "sra_neg");
    apply(1'b0, ALUOP_RTYPE, FN_SRL, 16'h8000, 16'h0004, 16'h0000, 16'h0800, 1'b0, "srl_neg");
    apply(1'b0, ALUOP_RTYPE, FN_SRL, 16'h8000, 16'h0014, 16'h0000, 16'h0800, 1'b0, "srl_shamt_low4");
    apply(1'b0, ALUOP_RTYPE, 4'd12,  16'd4, 16'd3, 16'd2, 16'h0000, 1'b1, "fn_unused12");
    apply(1'b0, ALUOP_ADD,   4'd12,  16'd4, 16'd3, 16'd2, 16'h0007, 1'b0, "fucn_ignored");

    // Wrap-around.
    apply(1'b0, ALUOP_RTYPE, FN_ADD, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b1, "wrap_add");
    apply(1'b0, ALUOP_RTYPE, FN_SUB, 16'h0000, 16'h0001, 16'h0000, 16'hFFFF, 1'b0, "wrap_sub");
    drain();

    // Asynchronous reset between edges, held across an edge, then released.
    apply(1'b0, ALUOP_ADD, 4'd0, 16'd4, 16'd3, 16'd2, 16'h0007, 1'b0, "pre_reset_add");
    drain();
    #2;
    inp_rst_n = 1'b0;
    #1;
    check_now(16'h0000, 1'b0, "reset_async");
    @(posedge inp_clk);
    #1;
    check_now(16'h0000, 1'b0, "reset_hold");
    @(negedge inp_clk);
    inp_rst_n = 1'b1;
    apply(1'b0, ALUOP_ADD, 4'd0, 16'd4, 16'd3, 16'd2, 16'h0007, 1'b0, "post_reset_add");
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_execute
